// File: rtl/instr_encoder_pkg.sv
// Shared op codes, opcode and funct values, and the instruction-word encoder.
// The control decoder imports the same package, so both sides agree on every field value.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_AND     = 3'd2,
        OP_OR      = 3'd3,
        OP_MUL     = 3'd4,
        OP_LOAD    = 3'd5,
        OP_STORE   = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'd4;
    localparam logic [5:0] OPC_LOAD  = 6'd5;
    localparam logic [5:0] OPC_STORE = 6'd6;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_MUL = 6'd50;

    function automatic logic is_legal(op_e op);
        return op != OP_ILLEGAL;
    endfunction

    function automatic logic [5:0] funct_of(op_e op);
        logic [5:0] f;
        f = 6'd0;
        case (op)
            OP_ADD:  f = FUNCT_ADD;
            OP_SUB:  f = FUNCT_SUB;
            OP_AND:  f = FUNCT_AND;
            OP_OR:   f = FUNCT_OR;
            OP_MUL:  f = FUNCT_MUL;
            default: f = 6'd0;
        endcase
        return f;
    endfunction

    // R-format carries the fixed shamt tag; LOAD/STORE ignore rd.
    function automatic logic [31:0] encode_instr(
        op_e         op,
        logic [4:0]  rs,
        logic [4:0]  rt,
        logic [4:0]  rd,
        logic [15:0] imm,
        logic [4:0]  shamt
    );
        logic [31:0] w;
        w = 32'd0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL:
                w = {OPC_RTYPE, rs, rt, rd, shamt, funct_of(op)};
            OP_LOAD:  w = {OPC_LOAD, rs, rt, imm};
            OP_STORE: w = {OPC_STORE, rs, rt, imm};
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo2.sv
// Two-entry FIFO holding {word address, encoded instruction} pairs.
// Flush empties it synchronously and wins over push and pop.
module instr_fifo2 #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU/memory requests into 32-bit instruction words, pairs each with its
// word address and hands them to the instruction-memory writer through a 2-entry FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int SHAMT_TAG = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    input  logic              clr_err,
    input  logic              flush
);

    localparam int ENTRY_W = ADDR_W + 32;

    // Handshakes: a transfer happens on the rising clk edge where valid and ready are
    // both 1; valid never waits on ready, and req_ready never depends on out_ready.

    op_e                op;
    logic               ready_en;
    logic [1:0]         occ;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] push_entry;
    logic               accept;
    logic               push;
    logic               pop;
    logic               illegal_acc;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [ADDR_W-1:0]  push_addr;
    logic [31:0]        enc_word;

    assign op = op_e'(req_op);

    // Holds req_ready low through reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign req_ready   = ready_en && (occ != 2'd2) && !flush;
    assign accept      = req_valid && req_ready;
    assign push        = accept && is_legal(op);
    assign illegal_acc = accept && !is_legal(op);
    assign pop         = fifo_valid && out_ready;

    assign enc_word = encode_instr(op, req_rs, req_rt, req_rd, req_imm, 5'(SHAMT_TAG));

    // addr_cnt is the address of the head word; a new word lands behind the occupants.
    assign push_addr  = addr_cnt + ADDR_W'(occ);
    assign push_entry = {push_addr, enc_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (flush) begin
            addr_cnt <= '0;
        end else if (pop) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // Setting the sticky flag outranks a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else if (illegal_acc) begin
            err_illegal <= 1'b1;
        end else if (clr_err) begin
            err_illegal <= 1'b0;
        end
    end

    instr_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (occ)
    );

    assign out_valid = fifo_valid;
    assign out_instr = fifo_head[31:0];
    assign out_addr  = fifo_head[ENTRY_W-1:32];

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [15:0]       req_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic              clr_err;
  logic              flush;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .SHAMT_TAG(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_illegal(err_illegal),
    .clr_err    (clr_err),
    .flush      (flush)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;
  logic              ready_on;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int imm);
    int unsigned functs[5] = '{32, 34, 36, 37, 50};
    int unsigned w;
    w = 0;
    if (op <= 4)
      w = 4 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + 10 * (1 << 6) + functs[op];
    else if (op == 5)
      w = 5 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else if (op == 6)
      w = 6 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    return 32'(w);
  endfunction

  task automatic set_req(input logic v, input int op, input int rs, input int rt, input int rd, input int imm);
    req_valid = v;
    req_op    = 3'(op);
    req_rs    = 5'(rs);
    req_rt    = 5'(rt);
    req_rd    = 5'(rd);
    req_imm   = 16'(imm);
  endtask

  task automatic rand_req(input int op);
    set_req(1'b1, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    logic exp_rdy;
    logic exp_ov;
    #1;
    exp_rdy = ready_on && (exp_q.size() < 2) && !flush;
    exp_ov  = (exp_q.size() != 0);
    chk("req_ready", req_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_instr", out_instr, exp_q[0]);
      chk("out_addr", out_addr, m_addr);
    end
    chk("err_illegal", err_illegal, m_err);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      m_addr = '0;
    end else begin
      if (exp_ov && out_ready) begin
        void'(exp_q.pop_front());
        m_addr++;
      end
      if (req_valid && exp_rdy && req_op != 3'd7)
        exp_q.push_back(ref_encode(req_op, req_rs, req_rt, req_rd, req_imm));
    end
    if (req_valid && exp_rdy && req_op == 3'd7) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
    ready_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_err", err_illegal, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    exp_q.delete();
    m_addr   = '0;
    m_err    = 1'b0;
    ready_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_req(1'b0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    clr_err   = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b1;
    m_addr    = '0;
    m_err     = 1'b0;
    ready_on  = 1'b0;
    @(negedge clk);
    do_reset();
    cycle();
    cycle();

    // ADD rs=1 rt=2 rd=3
    set_req(1'b1, 0, 1, 2, 3, 0);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();
    chk("add_word", out_instr, 32'h10221AA0);
    chk("add_addr", out_addr, 8'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // MUL then LOAD from address 0
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_req(1'b1, 4, 1, 2, 3, 0);
    cycle();
    set_req(1'b1, 5, 4, 5, 0, 16'h0010);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();
    chk("mul_word", out_instr, 32'h10221AB2);
    chk("mul_addr", out_addr, 8'd0);
    out_ready = 1'b1;
    cycle();
    chk("load_word", out_instr, 32'h14850010);
    chk("load_addr", out_addr, 8'd1);
    cycle();
    out_ready = 1'b0;

    // STORE with rd ignored
    set_req(1'b1, 6, 0, 7, 9, 16'hFFFC);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();
    chk("store_word", out_instr, 32'h1807FFFC);
    out_ready = 1'b1;
    cycle();

    // Back-pressure: third request refused, held words stay stable
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req($urandom_range(0, 6));
      cycle();
    end
    #1;
    chk("full_req_ready", req_ready, 1'b0);
    set_req(1'b0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Illegal op, clear, and set-beats-clear
    set_req(1'b1, 7, 3, 3, 3, 0);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();
    chk("illegal_err", err_illegal, 1'b1);
    chk("illegal_no_word", out_valid, 1'b0);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_err", err_illegal, 1'b0);
    set_req(1'b1, 7, 0, 0, 0, 0);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 0);
    chk("set_over_clr", err_illegal, 1'b1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    set_req(1'b1, 1, 2, 3, 4, 0);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();

    // Streaming past the address wrap, then flush mid-stream
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_req($urandom_range(0, 6));
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    rand_req(2);
    cycle();
    chk("flush_next_addr", out_addr, 8'd0);
    set_req(1'b0, 0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0) rand_req(($urandom_range(0, 7) == 7) ? 7 : $urandom_range(0, 6));
      else set_req(1'b0, 0, 0, 0, 0, 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      clr_err   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush   = 1'b0;
    clr_err = 1'b0;

    // Reset while words are buffered
    out_ready = 1'b0;
    rand_req(0);
    cycle();
    rand_req(5);
    cycle();
    set_req(1'b0, 0, 0, 0, 0, 0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the instruction word-address counter.
REQ-002 SHALL have parameter SHAMT_TAG, default 10, constant placed in bits [10:6] of every R-format word.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  encode request present.
REQ-006 SHALL have port req_ready  output  1  request accepted on the clk edge where req_valid and req_ready are both 1.
REQ-007 SHALL have port req_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 LOAD, 6 STORE, 7 illegal.
REQ-008 SHALL have ports req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-009 SHALL have port req_imm  input  16  offset for LOAD/STORE.
REQ-010 SHALL have port out_valid  output  1  encoded word available.
REQ-011 SHALL have port out_ready  input  1  consumer (instruction-memory writer) accepts word.
REQ-012 SHALL have port out_instr  output  32  encoded instruction.
REQ-013 SHALL have port out_addr  output  ADDR_W  word address paired with out_instr.
REQ-014 SHALL have port err_illegal  output  1  sticky illegal-op flag.
REQ-015 SHALL have port clr_err  input  1  synchronous clear of err_illegal.
REQ-016 SHALL have port flush  input  1  synchronous drop of buffered words and address reset.

Function
REQ-017 SHALL encode ADD/SUB/AND/OR/MUL as {6'd4, rs, rt, rd, SHAMT_TAG[4:0], funct}, funct = 32/34/36/37/50 respectively.
REQ-018 SHALL encode LOAD as {6'd5, rs, rt, imm} and STORE as {6'd6, rs, rt, imm}; req_rd ignored for both.
REQ-019 SHALL buffer encoded words in a 2-entry FIFO; req_ready = (occupancy < 2) AND NOT flush, with no combinational path from out_ready.
REQ-020 SHALL present an accepted request on out_* no earlier than the cycle after acceptance (1-cycle latency into an empty FIFO).
REQ-021 SHALL keep out_instr/out_addr stable while out_valid=1 and out_ready=0.
REQ-022 SHALL increment the word-address counter by 1 on each output handshake, wrapping from 2^ADDR_W-1 to 0; each FIFO entry stores the address assigned at push time.
REQ-023 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-024 SHALL drop an accepted op 7 (nothing pushed, address unchanged) and set err_illegal on the following edge.
REQ-025 SHALL give set priority over clr_err when both occur on the same edge.
REQ-026 SHALL, on flush, empty the FIFO and zero the address counter on that edge; flush has priority over push and pop.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out_instr=0, out_addr=0, err_illegal=0, FIFO empty and req_ready=0; req_ready rises on the first edge after release.
REQ-028 SHALL, on reset asserted mid-transfer, discard buffered words without emitting partial output.

Structure
REQ-029 SHALL take op codes, opcode values (4, 5, 6) and funct values from a shared package also used by the control decoder.
REQ-030 SHALL isolate the 2-entry FIFO as sub-module instr_fifo2.

Verification
REQ-031 SHALL cover ADD rs=1, rt=2, rd=3 -> out_instr=0x10221AA0, out_addr=0.
REQ-032 SHALL cover MUL rs=1, rt=2, rd=3, then LOAD rs=4, rt=5, imm=0x0010 -> 0x10221AB2 @0, then 0x14850010 @1.
REQ-033 SHALL cover STORE rs=0, rt=7, imm=0xFFFC, rd=9 -> 0x1807FFFC.
REQ-034 SHALL cover out_ready=0 with 3 requests -> req_ready low after 2; words held stable; order kept on release.
REQ-035 SHALL cover op 7 -> no out_valid, err_illegal=1, address unchanged; clr_err -> 0.
REQ-036 SHALL cover 256 words with ADDR_W=8 -> out_addr wraps 255->0; flush mid-stream -> out_valid=0 next cycle, next address 0.
